iobus_router: RTL and testbench
===============================

// Module: iobus_router
// PURPOSE
// - Parametrised successor of the MCS IO-bus interconnect: decodes an N-slot address window, strobes one core,
//   tracks the transaction, muxes the response back to the MicroBlaze MCS IO bus.
// - Adds a per-transaction timeout and a registered default response, so an unmapped or hung core never stalls the CPU.
// - Sits between the MCS IO port and all register-mapped cores (gcnt, pdm, prng, i2cm, ...).
// PARAMETERS
// - CORE_COUNT      4             number of core slots N (1..16)
// - BASE_ADDRESS    32'hC0000000  address of slot 0
// - ADDRESS_STRIDE  32'h1000      bytes per slot, power of two
// - TIMEOUT_CYCLES  255           cycles after strobe before forced error response (>=2)
// - DEFAULT_DATA    32'hDEADBEEF  read data returned on miss or timeout
// PORTS
// - io_clk            in   1      bus clock
// - io_rst            in   1      synchronous, active-high reset
// - io_addr_strobe    in   1      upstream transaction start
// - io_address        in   32     upstream address
// - io_read_data      out  32     response data to CPU
// - io_ready          out  1      response valid, one-cycle pulse
// - core_addr_strobe  out  N      one-hot strobe to selected core
// - core_read_data    in   32*N   packed core read data, slot i at [32*i +: 32]
// - core_ready        in   N      per-core ready
// - err_valid         out  1      sticky error flag
// - err_addr          out  32     address of first failed access
// - err_timeout       out  1      1 = first error was a timeout, 0 = a miss
// - err_clear         in   1      clears err_valid/err_addr/err_timeout
// - Read/write strobes, byte enables and write data go straight from CPU to cores, outside this block.
// BEHAVIOUR
// - Reset: state IDLE, sel=0, cnt=0, io_ready=0, io_read_data=0, core_addr_strobe=0, err_*=0.
// - Decode: hit = BASE_ADDRESS <= addr < BASE_ADDRESS+N*ADDRESS_STRIDE; idx = (addr-BASE_ADDRESS)/ADDRESS_STRIDE.
//   Decode is combinational. core_addr_strobe[idx] = io_addr_strobe & hit & (state==IDLE), same cycle as the strobe.
// - FSM IDLE: on strobe+hit, latch sel=idx, cnt=0, go BUSY. On strobe+miss go DFLT.
//   core_ready in IDLE is ignored.
// - FSM BUSY: io_ready = core_ready[sel], io_read_data = core_read_data[sel] (combinational, zero added latency),
//   then go IDLE. Otherwise cnt++. When cnt==TIMEOUT_CYCLES-1 with no ready, go DFLT.
//   Cores respond >=1 cycle after the strobe.
// - FSM DFLT: one cycle with io_ready=1 and io_read_data=DEFAULT_DATA, then go IDLE.
//   Miss latency 1 cycle; timeout response comes TIMEOUT_CYCLES cycles after the strobe.
// - io_read_data is 0 whenever io_ready=0.
// - Late core_ready from a timed-out core arrives in IDLE and is dropped; it never produces a second io_ready.
// - A strobe outside IDLE is a protocol violation. It is ignored: no core strobe, no state change.
// - Reset mid-transaction: back to IDLE next edge, no io_ready issued.
// - cnt width is $clog2(TIMEOUT_CYCLES+1); cnt saturates and never wraps.
// CONFIGURATION
// - IOBUS_ROUTER_ERR_CAPTURE_EN defined: the first miss or timeout sets err_valid and captures err_addr/err_timeout.
//   Later errors do not overwrite until err_clear. err_clear and a new error in the same cycle: the new error wins.
// - Not defined: err_valid, err_addr and err_timeout tied to 0; err_clear ignored; no capture registers.
// STRUCTURE
// - Package iobus_pkg: state enum {IDLE,BUSY,DFLT}, IOBUS_DATA_W=32, IOBUS_ADDR_W=32, default DEFAULT_DATA constant.
// - Sub-module iobus_slot_decode (combinational): address -> {hit, idx}.
//   FSM, counter, response mux and error capture stay in iobus_router.
// TESTING
// - Strobe 0xC0001004, core1 ready 3 cycles later with 0x12345678 -> core_addr_strobe=4'b0010 in strobe cycle;
//   io_ready one cycle, data 0x12345678.
// - Strobe 0xC0004000 (N=4, miss) -> no core strobe; io_ready next cycle, data 0xDEADBEEF; err_valid=1, err_timeout=0.
// - Strobe 0xC0002000, core2 never ready, TIMEOUT_CYCLES=8 -> io_ready exactly 8 cycles after strobe with 0xDEADBEEF;
//   err_timeout=1.
// - Core2 ready at cycle 10, after that timeout -> no second io_ready; next access to core0 completes normally.
// - io_rst asserted while BUSY -> next cycle all outputs 0, state IDLE; a following access succeeds.
// - Error capture: two misses, then err_clear plus a third miss in the same cycle -> err_addr holds the first miss,
//   then the third; the macro undefined -> err_* stay 0 throughout.

Source files
------------

// File: rtl/iobus_pkg.sv
// Shared types and constants for the MCS IO-bus router: FSM state encoding, bus widths,
// the default miss/timeout response word and the slot-index width helper.
package iobus_pkg;

    localparam int IOBUS_DATA_W = 32;
    localparam int IOBUS_ADDR_W = 32;
    localparam logic [IOBUS_DATA_W-1:0] IOBUS_DEFAULT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DFLT = 2'd2
    } iobus_state_e;

    // A single-slot router still needs a one-bit index so port widths never collapse to zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iobus_router_if.sv
// Upstream MicroBlaze MCS IO-bus handshake: the CPU side is the master, the router the slave.
interface iobus_router_if;

    logic                             io_addr_strobe;
    logic [iobus_pkg::IOBUS_ADDR_W-1:0] io_address;
    logic [iobus_pkg::IOBUS_DATA_W-1:0] io_read_data;
    logic                             io_ready;

    modport master (
        output io_addr_strobe,
        output io_address,
        input  io_read_data,
        input  io_ready
    );

    modport slave (
        input  io_addr_strobe,
        input  io_address,
        output io_read_data,
        output io_ready
    );

endinterface

// File: rtl/iobus_slot_decode.sv
// Combinational address-window decoder: maps an IO-bus address onto one of CORE_COUNT
// equally sized, power-of-two slots starting at BASE_ADDRESS.
module iobus_slot_decode
    import iobus_pkg::*;
#(
    parameter int                      CORE_COUNT     = 4,
    parameter logic [IOBUS_ADDR_W-1:0] BASE_ADDRESS   = 32'hC000_0000,
    parameter logic [IOBUS_ADDR_W-1:0] ADDRESS_STRIDE = 32'h0000_1000,
    parameter int                      IDX_W          = 2
) (
    input  logic [IOBUS_ADDR_W-1:0] addr,
    output logic                    hit,
    output logic [IDX_W-1:0]        idx
);

    localparam int STRIDE_SHIFT = $clog2(ADDRESS_STRIDE);
    // One extra bit so the window end never overflows, even for a window touching 2**32.
    localparam logic [IOBUS_ADDR_W:0] SPAN =
        (IOBUS_ADDR_W+1)'(CORE_COUNT) * {1'b0, ADDRESS_STRIDE};

    logic [IOBUS_ADDR_W-1:0] offset_s;

    // Offset from the window base, range check and slot index.
    always_comb begin
        offset_s = addr - BASE_ADDRESS;
        hit      = (addr >= BASE_ADDRESS) && ({1'b0, offset_s} < SPAN);
        if (hit) begin
            idx = IDX_W'(offset_s >> STRIDE_SHIFT);
        end else begin
            idx = {IDX_W{1'b0}};
        end
    end

endmodule

// File: rtl/iobus_router.sv
// MCS IO-bus router: decodes the slot window, strobes one core, tracks the transaction with a timeout
// and returns a default response on miss/timeout. Optional error capture: IOBUS_ROUTER_ERR_CAPTURE_EN.
module iobus_router
    import iobus_pkg::*;
#(
    parameter int                      CORE_COUNT     = 4,
    parameter logic [IOBUS_ADDR_W-1:0] BASE_ADDRESS   = 32'hC000_0000,
    parameter logic [IOBUS_ADDR_W-1:0] ADDRESS_STRIDE = 32'h0000_1000,
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [IOBUS_DATA_W-1:0] DEFAULT_DATA   = IOBUS_DEFAULT_DATA
) (
    input  logic                               io_clk,
    input  logic                               io_rst,
    iobus_router_if.slave                      bus,
    output logic [CORE_COUNT-1:0]              core_addr_strobe,
    input  logic [IOBUS_DATA_W*CORE_COUNT-1:0] core_read_data,
    input  logic [CORE_COUNT-1:0]              core_ready,
    output logic                               err_valid,
    output logic [IOBUS_ADDR_W-1:0]            err_addr,
    output logic                               err_timeout,
    input  logic                               err_clear
);

    localparam int IDX_W = idx_width(CORE_COUNT);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // cnt_r holds completed BUSY cycles; the timeout fires on the cycle it would reach TIMEOUT_CYCLES-1,
    // so the DFLT response lands exactly TIMEOUT_CYCLES cycles after the strobe.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    iobus_state_e      state_r;
    logic [IDX_W-1:0]  sel_r;
    logic [CNT_W-1:0]  cnt_r;

    logic                    hit_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    accept_s;
    logic                    miss_s;
    logic                    sel_ready_s;
    logic [IOBUS_DATA_W-1:0] sel_data_s;
    logic                    timeout_s;

    iobus_slot_decode #(
        .CORE_COUNT     (CORE_COUNT),
        .BASE_ADDRESS   (BASE_ADDRESS),
        .ADDRESS_STRIDE (ADDRESS_STRIDE),
        .IDX_W          (IDX_W)
    ) u_decode (
        .addr (bus.io_address),
        .hit  (hit_s),
        .idx  (idx_s)
    );

    // Transaction start/miss qualification and the selected core's response.
    always_comb begin
        accept_s = 1'b0;
        miss_s   = 1'b0;
        if ((state_r == IDLE) && bus.io_addr_strobe) begin
            accept_s = hit_s;
            miss_s   = !hit_s;
        end else begin
            accept_s = 1'b0;
            miss_s   = 1'b0;
        end
        sel_ready_s = core_ready[sel_r];
        sel_data_s  = core_read_data[{sel_r, 5'd0} +: IOBUS_DATA_W];
        timeout_s   = (state_r == BUSY) && !sel_ready_s && (cnt_r == CNT_LAST);
    end

    // One-hot core strobe in the same cycle as the accepted upstream strobe.
    always_comb begin
        core_addr_strobe = {CORE_COUNT{1'b0}};
        for (int i = 0; i < CORE_COUNT; i++) begin
            core_addr_strobe[i] = accept_s && (idx_s == IDX_W'(i));
        end
    end

    // Response mux; read data is forced to zero whenever io_ready is low.
    always_comb begin
        bus.io_ready     = 1'b0;
        bus.io_read_data = {IOBUS_DATA_W{1'b0}};
        case (state_r)
            BUSY: begin
                if (sel_ready_s) begin
                    bus.io_ready     = 1'b1;
                    bus.io_read_data = sel_data_s;
                end else begin
                    bus.io_ready     = 1'b0;
                    bus.io_read_data = {IOBUS_DATA_W{1'b0}};
                end
            end
            DFLT: begin
                bus.io_ready     = 1'b1;
                bus.io_read_data = DEFAULT_DATA;
            end
            default: begin
                bus.io_ready     = 1'b0;
                bus.io_read_data = {IOBUS_DATA_W{1'b0}};
            end
        endcase
    end

    // Transaction FSM with slot latch and saturating timeout counter.
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_r <= IDLE;
            sel_r   <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sel_r   <= idx_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= BUSY;
                    end else if (miss_s) begin
                        state_r <= DFLT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (sel_ready_s) begin
                        state_r <= IDLE;
                    end else begin
                        if (cnt_r != CNT_MAX) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                        if (timeout_s) begin
                            state_r <= DFLT;
                        end
                    end
                end
                DFLT: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef IOBUS_ROUTER_ERR_CAPTURE_EN
    logic                    err_valid_r;
    logic [IOBUS_ADDR_W-1:0] err_addr_r;
    logic                    err_timeout_r;
    logic [IOBUS_ADDR_W-1:0] addr_r;

    // Address of the transaction in flight, needed to report a timeout.
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            addr_r <= {IOBUS_ADDR_W{1'b0}};
        end else if (accept_s) begin
            addr_r <= bus.io_address;
        end
    end

    // First-error capture; a new error in the clear cycle re-arms and is captured.
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            err_valid_r   <= 1'b0;
            err_addr_r    <= {IOBUS_ADDR_W{1'b0}};
            err_timeout_r <= 1'b0;
        end else if ((miss_s || timeout_s) && (!err_valid_r || err_clear)) begin
            err_valid_r   <= 1'b1;
            err_addr_r    <= miss_s ? bus.io_address : addr_r;
            err_timeout_r <= timeout_s;
        end else if (err_clear) begin
            err_valid_r   <= 1'b0;
            err_addr_r    <= {IOBUS_ADDR_W{1'b0}};
            err_timeout_r <= 1'b0;
        end
    end

    assign err_valid   = err_valid_r;
    assign err_addr    = err_addr_r;
    assign err_timeout = err_timeout_r;
`else
    logic unused_err_clear_s;

    assign unused_err_clear_s = err_clear;
    assign err_valid          = 1'b0;
    assign err_addr           = {IOBUS_ADDR_W{1'b0}};
    assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_iobus_router.sv
// Table-driven bench for iobus_router (4 slots, TIMEOUT_CYCLES=8): one vector per clock cycle,
// plus a hand-written timeout-latency measurement.
module tb_iobus_router;

`ifdef IOBUS_ROUTER_ERR_CAPTURE_EN
    localparam bit ERR_CAP = 1'b1;
`else
    localparam bit ERR_CAP = 1'b0;
`endif

    localparam logic [31:0] D0 = 32'hA0A0_0000;
    localparam logic [31:0] D1 = 32'h1234_5678;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] Z  = 32'h0000_0000;

    typedef struct {
        logic        rst;
        logic        stb;
        logic [31:0] addr;
        logic [3:0]  rdy;
        logic        clr;
        logic [3:0]  e_cstb;
        logic        e_rdy;
        logic [31:0] e_data;
        logic        e_ev;
        logic [31:0] e_ea;
        logic        e_et;
    } vec_t;

    logic         io_clk = 1'b0;
    logic         io_rst;
    logic [3:0]   core_addr_strobe;
    logic [127:0] core_read_data;
    logic [3:0]   core_ready;
    logic         err_valid;
    logic [31:0]  err_addr;
    logic         err_timeout;
    logic         err_clear;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    iobus_router_if bus();

    iobus_router #(
        .CORE_COUNT     (4),
        .BASE_ADDRESS   (32'hC000_0000),
        .ADDRESS_STRIDE (32'h0000_1000),
        .TIMEOUT_CYCLES (8),
        .DEFAULT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .io_clk           (io_clk),
        .io_rst           (io_rst),
        .bus              (bus),
        .core_addr_strobe (core_addr_strobe),
        .core_read_data   (core_read_data),
        .core_ready       (core_ready),
        .err_valid        (err_valid),
        .err_addr         (err_addr),
        .err_timeout      (err_timeout),
        .err_clear        (err_clear)
    );

    always #5 io_clk = ~io_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic stb, input logic [31:0] addr, input logic [3:0] rdy,
                       input logic clr, input logic [3:0] e_cstb, input logic e_rdy, input logic [31:0] e_data,
                       input logic e_ev, input logic [31:0] e_ea, input logic e_et);
        vec_t v;
        v.rst = rst; v.stb = stb; v.addr = addr; v.rdy = rdy; v.clr = clr;
        v.e_cstb = e_cstb; v.e_rdy = e_rdy; v.e_data = e_data;
        v.e_ev = e_ev; v.e_ea = e_ea; v.e_et = e_et;
        vq.push_back(v);
    endtask

    initial begin
        int          lat;
        logic [31:0] to_data;
        bit          seen;

        core_read_data       = {D3, D2, D1, D0};
        io_rst               = 1'b1;
        bus.io_addr_strobe   = 1'b0;
        bus.io_address       = Z;
        core_ready           = 4'b0000;
        err_clear            = 1'b0;

        // rst stb addr          rdy      clr   cstb     rdy   data  ev    ea             et
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b0, Z,             1'b0); // reset state
        add(1'b0, 1'b1, 32'hC0001004, 4'b0000, 1'b0, 4'b0010, 1'b0, Z,  1'b0, Z,             1'b0); // core1 read
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b0, Z,             1'b0);
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b0, Z,             1'b0);
        add(1'b0, 1'b0, Z,            4'b0010, 1'b0, 4'b0000, 1'b1, D1, 1'b0, Z,             1'b0);
        add(1'b0, 1'b0, Z,            4'b0010, 1'b0, 4'b0000, 1'b0, Z,  1'b0, Z,             1'b0); // ready in IDLE
        add(1'b0, 1'b1, 32'hC0004000, 4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b0, Z,             1'b0); // miss above
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b1, DB, 1'b1, 32'hC0004000, 1'b0);
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b1, 32'hC0004000, 1'b0);
        add(1'b0, 1'b1, 32'hBFFFFFFC, 4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b1, 32'hC0004000, 1'b0); // miss below
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b1, DB, 1'b1, 32'hC0004000, 1'b0);
        add(1'b0, 1'b1, 32'hC0003FFC, 4'b0000, 1'b0, 4'b1000, 1'b0, Z,  1'b1, 32'hC0004000, 1'b0); // last byte
        add(1'b0, 1'b0, Z,            4'b1000, 1'b0, 4'b0000, 1'b1, D3, 1'b1, 32'hC0004000, 1'b0);
        add(1'b0, 1'b1, 32'hC0000000, 4'b0000, 1'b0, 4'b0001, 1'b0, Z,  1'b1, 32'hC0004000, 1'b0); // first byte
        add(1'b0, 1'b1, 32'hC0002000, 4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b1, 32'hC0004000, 1'b0); // strobe in BUSY
        add(1'b0, 1'b0, Z,            4'b0101, 1'b0, 4'b0000, 1'b1, D0, 1'b1, 32'hC0004000, 1'b0);
        add(1'b0, 1'b0, Z,            4'b0000, 1'b1, 4'b0000, 1'b0, Z,  1'b1, 32'hC0004000, 1'b0); // clear
        add(1'b0, 1'b1, 32'hC0002000, 4'b0000, 1'b0, 4'b0100, 1'b0, Z,  1'b0, Z,             1'b0); // core2 hangs
        for (int k = 0; k < 7; k++)
            add(1'b0, 1'b0, Z,        4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b0, Z,             1'b0);
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b1, DB, 1'b1, 32'hC0002000, 1'b1); // 8 after strobe
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b1, 32'hC0002000, 1'b1);
        add(1'b0, 1'b0, Z,            4'b0100, 1'b0, 4'b0000, 1'b0, Z,  1'b1, 32'hC0002000, 1'b1); // late ready
        add(1'b0, 1'b1, 32'hC0000010, 4'b0000, 1'b0, 4'b0001, 1'b0, Z,  1'b1, 32'hC0002000, 1'b1);
        add(1'b0, 1'b0, Z,            4'b0001, 1'b0, 4'b0000, 1'b1, D0, 1'b1, 32'hC0002000, 1'b1);
        add(1'b0, 1'b1, 32'hC0001000, 4'b0000, 1'b0, 4'b0010, 1'b0, Z,  1'b1, 32'hC0002000, 1'b1);
        add(1'b1, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b1, 32'hC0002000, 1'b1); // reset in BUSY
        add(1'b0, 1'b0, Z,            4'b0010, 1'b0, 4'b0000, 1'b0, Z,  1'b0, Z,             1'b0);
        add(1'b0, 1'b1, 32'hC0001000, 4'b0000, 1'b0, 4'b0010, 1'b0, Z,  1'b0, Z,             1'b0);
        add(1'b0, 1'b0, Z,            4'b0010, 1'b0, 4'b0000, 1'b1, D1, 1'b0, Z,             1'b0);
        add(1'b0, 1'b1, 32'hC0005000, 4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b0, Z,             1'b0); // miss #1
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b1, DB, 1'b1, 32'hC0005000, 1'b0);
        add(1'b0, 1'b1, 32'hC000F000, 4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b1, 32'hC0005000, 1'b0); // miss #2
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b1, DB, 1'b1, 32'hC0005000, 1'b0);
        add(1'b0, 1'b1, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, Z,  1'b1, 32'hC0005000, 1'b0); // miss #3 + clear
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b1, DB, 1'b1, 32'h00000000, 1'b0);
        add(1'b0, 1'b0, Z,            4'b0000, 1'b0, 4'b0000, 1'b0, Z,  1'b1, 32'h00000000, 1'b0);

        repeat (2) @(negedge io_clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge io_clk);
            io_rst             = vq[i].rst;
            bus.io_addr_strobe = vq[i].stb;
            bus.io_address     = vq[i].addr;
            core_ready         = vq[i].rdy;
            err_clear          = vq[i].clr;
            #2;
            check($sformatf("v%0d core_addr_strobe", i), {28'd0, core_addr_strobe}, {28'd0, vq[i].e_cstb});
            check($sformatf("v%0d io_ready", i), {31'd0, bus.io_ready}, {31'd0, vq[i].e_rdy});
            check($sformatf("v%0d io_read_data", i), bus.io_read_data, vq[i].e_data);
            check($sformatf("v%0d err_valid", i), {31'd0, err_valid}, {31'd0, ERR_CAP ? vq[i].e_ev : 1'b0});
            check($sformatf("v%0d err_addr", i), err_addr, ERR_CAP ? vq[i].e_ea : Z);
            check($sformatf("v%0d err_timeout", i), {31'd0, err_timeout}, {31'd0, ERR_CAP ? vq[i].e_et : 1'b0});
        end

        // Hand-written: measure the timeout latency of a hung core3 with a bounded wait.
        @(negedge io_clk);
        io_rst             = 1'b0;
        err_clear          = 1'b0;
        core_ready         = 4'b0000;
        bus.io_addr_strobe = 1'b1;
        bus.io_address     = 32'hC0003000;
        #2;
        check("to_strobe", {28'd0, core_addr_strobe}, {28'd0, 4'b1000});
        lat     = 0;
        to_data = Z;
        seen    = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge io_clk);
            bus.io_addr_strobe = 1'b0;
            bus.io_address     = Z;
            #2;
            if (bus.io_ready) begin
                seen    = 1'b1;
                lat     = c;
                to_data = bus.io_read_data;
            end
        end
        check("to_latency", lat, 8);
        check("to_data", to_data, DB);
        @(negedge io_clk);
        #2;
        check("to_single_pulse", {31'd0, bus.io_ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
